// File: rtl/mlp_seq_engine.sv
// mlp_seq_engine: time-multiplexed two-layer MLP (ReLU hidden, argmax output) with P shared MAC lanes and a parameter load port.
module mlp_seq_engine #(
  parameter int N  = 8,
  parameter int M  = 6,
  parameter int I  = 62,
  parameter int H  = 30,
  parameter int O  = 10,
  parameter int P  = 6,
  parameter int AW = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic                  start,
  input  logic [I*N-1:0]        data,
  input  logic                  wr_en,
  input  logic                  wr_layer,
  input  logic                  wr_bias,
  input  logic [AW-1:0]         wr_addr,
  input  logic [N-1:0]          wr_data,
  output logic                  busy,
  output logic                  done,
  output logic [$clog2(O)-1:0]  label,
  output logic [N-1:0]          score
);
  function automatic int cw(input int x);
    return x > 1 ? $clog2(x) : 1;
  endfunction
  localparam int LW   = $clog2(O);
  localparam int HG   = (H + P - 1) / P;
  localparam int OG   = (O + P - 1) / P;
  localparam int FM   = I > H ? I : H;
  localparam int ACCW = 2 * N + $clog2(FM) + 1;
  localparam int PW   = 2 * N;
  localparam int CW   = cw(FM + 2);
  localparam int GW   = cw(HG > OG ? HG : OG);
  localparam int HWA  = cw(H * I);
  localparam int OWA  = cw(O * H);
  localparam int HXA  = cw(H);
  localparam int OBA  = cw(O);
  localparam logic signed [ACCW-1:0] SMAX = ACCW'(2 ** (N - 1) - 1);
  localparam logic signed [ACCW-1:0] SMIN = -SMAX;

  typedef enum logic [1:0] {IDLE, HID, OUT, ARG} state_t;

  function automatic logic signed [N-1:0] sm2tc(input logic [N-1:0] v);
    return v[N-1] ? -$signed({1'b0, v[N-2:0]}) : $signed({1'b0, v[N-2:0]});
  endfunction

  function automatic logic [N-1:0] tc2sm(input logic signed [N-1:0] v);
    logic [N-1:0] m;
    m = v[N-1] ? -v : v;
    return {v[N-1], m[N-2:0]};
  endfunction

  logic [N-1:0] hw [H*I];
  logic [N-1:0] hb [H];
  logic [N-1:0] ow [O*H];
  logic [N-1:0] ob [O];
  logic signed [N-1:0] hid [H];
  logic signed [N-1:0] outv [O];
  logic [I*N-1:0] smp;

  state_t st, st_n;
  logic [CW-1:0] c;
  logic [GW-1:0] g;
  int fan, k, ki, kh, u;
  logic last_c, last_g;
  logic signed [N-1:0] x_cur;
  logic signed [N-1:0] lane_w [P];
  logic signed [N-1:0] lane_b [P];
  logic signed [N-1:0] res [P];
  logic signed [PW-1:0] prod [P];
  logic signed [ACCW-1:0] acc [P];
  logic signed [ACCW-1:0] sh [P];
  logic [HXA-1:0] lane_hi [P];
  logic [OBA-1:0] lane_oi [P];
  logic lane_ok [P];
  logic [LW-1:0] best_i;
  logic signed [N-1:0] best_v;

  always_comb begin
    fan = st == OUT ? H : I;
    last_c = int'(c) == fan + 1;
    last_g = int'(g) == (st == OUT ? OG : HG) - 1;
    k = (c != '0 && int'(c) <= fan) ? int'(c) - 1 : 0;
    ki = k < I ? k : 0;
    kh = k < H ? k : 0;
    x_cur = st == OUT ? hid[HXA'(kh)] : sm2tc(smp[ki*N +: N]);
    u = 0;
    for (int l = 0; l < P; l++) begin
      u = int'(g) * P + l;
      lane_ok[l] = u < (st == OUT ? O : H);
      lane_hi[l] = HXA'(u < H ? u : 0);
      lane_oi[l] = OBA'(u < O ? u : 0);
      lane_w[l] = sm2tc(st == OUT ? ow[OWA'(int'(lane_oi[l]) * H + kh)] : hw[HWA'(int'(lane_hi[l]) * I + ki)]);
      lane_b[l] = sm2tc(st == OUT ? ob[lane_oi[l]] : hb[lane_hi[l]]);
      prod[l] = PW'(x_cur) * PW'(lane_w[l]);
      sh[l] = acc[l] >>> M;
      // hidden results clamp negatives to zero before the lower saturation bound applies
      res[l] = sh[l] > SMAX ? N'(SMAX) : (sh[l] < 0 && st != OUT) ? '0 : sh[l] < SMIN ? N'(SMIN) : N'(sh[l]);
    end
    best_i = '0;
    best_v = outv[0];
    for (int o = 1; o < O; o++)
      if (outv[o] > best_v) begin
        best_i = LW'(o);
        best_v = outv[o];
      end
    st_n = st == IDLE ? (start ? HID : IDLE) :
           st == ARG  ? IDLE :
           (last_c && last_g) ? (st == HID ? OUT : ARG) : st;
  end

  always_ff @(posedge clk)
    if (rst) st <= IDLE;
    else if (clk_en) st <= st_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      label <= '0;
      score <= '0;
      c     <= '0;
      g     <= '0;
    end else if (clk_en) begin
      done <= st == ARG;
      if (st == IDLE && start) begin
        busy <= 1'b1;
        c    <= '0;
        g    <= '0;
      end
      if (st == HID || st == OUT) begin
        c <= last_c ? '0 : c + CW'(1);
        if (last_c) g <= last_g ? '0 : g + GW'(1);
      end
      if (st == ARG) begin
        label <= best_i;
        score <= tc2sm(best_v);
        busy  <= 1'b0;
      end
    end
  end

  // datapath state needs no reset: every group reloads its accumulators from the bias
  always_ff @(posedge clk)
    if (clk_en) begin
      if (st == IDLE && start) smp <= data;
      if (st == HID || st == OUT)
        for (int l = 0; l < P; l++) begin
          if (c == '0) acc[l] <= ACCW'(lane_b[l]) <<< M;
          else if (!last_c) acc[l] <= acc[l] + ACCW'(prod[l]);
          else if (lane_ok[l]) begin
            if (st == HID) hid[lane_hi[l]] <= res[l];
            else outv[lane_oi[l]] <= res[l];
          end
        end
    end

  always_ff @(posedge clk)
    if (wr_en && clk_en && !busy) begin
      if (!wr_layer && !wr_bias && wr_addr < AW'(H * I)) hw[HWA'(wr_addr)] <= wr_data;
      if (!wr_layer &&  wr_bias && wr_addr < AW'(H))     hb[HXA'(wr_addr)] <= wr_data;
      if ( wr_layer && !wr_bias && wr_addr < AW'(O * H)) ow[OWA'(wr_addr)] <= wr_data;
      if ( wr_layer &&  wr_bias && wr_addr < AW'(O))     ob[OBA'(wr_addr)] <= wr_data;
    end
endmodule

// File: tb/tb_mlp_seq_engine.sv
// tb_mlp_seq_engine: directed checks of latency, saturation, ReLU, ties, throttling and reset for a small engine.
module tb_mlp_seq_engine;
  localparam int N = 8, M = 6, I = 4, H = 3, O = 2, P = 2, AW = 11;

  logic clk = 1'b0;
  logic rst, clk_en, start, wr_en, wr_layer, wr_bias;
  logic [I*N-1:0] data;
  logic [AW-1:0] wr_addr;
  logic [N-1:0] wr_data;
  logic busy, done;
  logic [0:0] label;
  logic [N-1:0] score;
  int checks = 0;
  int errors = 0;

  mlp_seq_engine #(.N(N), .M(M), .I(I), .H(H), .O(O), .P(P), .AW(AW)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .start(start), .data(data),
    .wr_en(wr_en), .wr_layer(wr_layer), .wr_bias(wr_bias), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .label(label), .score(score)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input bit layer, input bit bias, input int addr, input logic [N-1:0] v);
    wr_en = 1'b1;
    wr_layer = layer;
    wr_bias = bias;
    wr_addr = AW'(addr);
    wr_data = v;
    step();
    wr_en = 1'b0;
  endtask

  task automatic cfg_sat();
    for (int u = 0; u < H; u++) begin
      for (int k = 0; k < I; k++) wr(0, 0, u * I + k, k == 0 ? 8'h40 : 8'h00);
      wr(0, 1, u, 8'h00);
    end
    for (int o = 0; o < O; o++) begin
      for (int j = 0; j < H; j++) wr(1, 0, o * H + j, o == 1 ? 8'h40 : 8'h00);
      wr(1, 1, o, 8'h00);
    end
  endtask

  task automatic cfg_bias(input logic [N-1:0] hbv, input logic [N-1:0] ob0, input logic [N-1:0] ob1);
    for (int a = 0; a < H * I; a++) wr(0, 0, a, 8'h00);
    for (int a = 0; a < O * H; a++) wr(1, 0, a, 8'h00);
    for (int u = 0; u < H; u++) wr(0, 1, u, hbv);
    wr(1, 1, 0, ob0);
    wr(1, 1, 1, ob1);
  endtask

  task automatic run(input string tag, input bit thr, input int el, input int es, input int en);
    int n;
    data = {I{8'h40}};
    start = 1'b1;
    clk_en = 1'b1;
    step();
    start = 1'b0;
    data = '0;
    chk({tag, "_busy_up"}, 32'(busy), 1);
    n = 0;
    while (!done && n < 200) begin
      clk_en = thr ? (n % 2 == 1) : 1'b1;
      if (thr && n == 3) begin
        wr_en = 1'b1; wr_layer = 1'b1; wr_bias = 1'b1; wr_addr = '0; wr_data = 8'h7F;
      end
      if (thr && n == 9) start = 1'b1;
      step();
      n++;
      wr_en = 1'b0;
      start = 1'b0;
    end
    chk({tag, "_latency"}, 32'(n), 32'(en));
    chk({tag, "_label"}, 32'(label), 32'(el));
    chk({tag, "_score"}, 32'(score), 32'(es));
    chk({tag, "_busy_down"}, 32'(busy), 0);
    if (thr) begin
      clk_en = 1'b0;
      step();
      chk({tag, "_done_hold"}, 32'(done), 1);
    end
    clk_en = 1'b1;
    step();
    chk({tag, "_done_pulse"}, 32'(done), 0);
    chk({tag, "_label_held"}, 32'(label), 32'(el));
  endtask

  initial begin
    int seen;
    rst = 1'b1; clk_en = 1'b1; start = 1'b1; data = {I{8'h40}};
    wr_en = 1'b0; wr_layer = 1'b0; wr_bias = 1'b0; wr_addr = '0; wr_data = '0;
    step();
    step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_label", 32'(label), 0);
    chk("rst_score", 32'(score), 0);
    rst = 1'b0;
    start = 1'b0;
    step();
    chk("rst_start_ignored", 32'(busy), 0);

    cfg_sat();
    run("sat", 0, 1, 'h7F, 18);
    run("throttle", 1, 1, 'h7F, 18 * 2);
    run("mem_intact", 0, 1, 'h7F, 18);

    data = {I{8'h40}};
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (done) seen++;
    end
    chk("midrst_no_done", 32'(seen), 0);
    run("rerun", 0, 1, 'h7F, 18);

    cfg_bias(8'hC0, 8'h10, 8'h20);
    run("relu", 0, 1, 'h20, 18);
    wr(1, 1, 0, 8'hA0);
    wr(1, 1, 1, 8'h90);
    run("neg_bias", 0, 1, 'h90, 18);
    wr(1, 1, 0, 8'h20);
    wr(1, 1, 1, 8'h20);
    wr(1, 1, 2, 8'h7F);
    run("tie", 0, 0, 'h20, 18);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
